// File: rtl/cdc_map_pkg.sv
// ---------------------------------------------------------------------------
// cdc_map_pkg
// Purpose : Shared address-map constants and the decoded-strobe record for
//           the CDC bus interface of the FIR block.
//           The CDC address space is 6 bits wide:
//             - bit 5 = 0 : 32-word coefficient/sample RAM, offsets 0..31
//             - bit 5 = 1 : control-register bank. Only offsets 0..7 are
//                           mapped. Offsets 8..31 are unmapped.
// Contents: address-map localparams, the cdc_dec_t struct, the reset value
//           of that struct, and a helper that says whether a register-region
//           offset is mapped.
// ---------------------------------------------------------------------------
package cdc_map_pkg;

  localparam int CDC_ADDR_W = 6;
  localparam int RAM_ADDR_W = 5;
  localparam int REG_IDX_W  = 3;
  localparam int REGION_BIT = 5;
  localparam int NUM_REGS   = 8;

  // Decoded strobes for one sampled CDC cycle.
  typedef struct packed {
    logic                  mux;       // read-mux select: 0 = RAM, 1 = registers
    logic [RAM_ADDR_W-1:0] ram_addr;  // RAM word address
    logic                  wr_ram;    // RAM write strobe
    logic [REG_IDX_W-1:0]  reg_idx;   // register index
    logic                  wr_rej;    // register write strobe
    logic                  err;       // unmapped register access
  } cdc_dec_t;

  localparam cdc_dec_t CDC_DEC_RESET = '{
    mux:      1'b0,
    ram_addr: {RAM_ADDR_W{1'b0}},
    wr_ram:   1'b0,
    reg_idx:  {REG_IDX_W{1'b0}},
    wr_rej:   1'b0,
    err:      1'b0
  };

  // A register-region offset is mapped only when its bits above the register
  // index are all zero. With 8 registers and 5 offset bits, that means
  // offsets 0..7.
  function automatic logic reg_offset_mapped(input logic [RAM_ADDR_W-1:0] off);
    return (off[RAM_ADDR_W-1:REG_IDX_W] == {(RAM_ADDR_W-REG_IDX_W){1'b0}});
  endfunction

endpackage

// File: rtl/cdc_addr_decode_comb.sv
// ---------------------------------------------------------------------------
// cdc_addr_decode_comb
// Purpose : Pure combinational decode of one CDC address/write request into
//           per-target strobes.
// Ports   : cdc_a_i   in  CDC_ADDR_W  CDC address (bit 5 = region select)
//           cdc_wr_i  in  1           write request
//           dec_o     out cdc_dec_t   decoded strobes (not registered)
// ---------------------------------------------------------------------------
module cdc_addr_decode_comb
  import cdc_map_pkg::*;
(
  input  logic [CDC_ADDR_W-1:0] cdc_a_i,
  input  logic                  cdc_wr_i,
  output cdc_dec_t              dec_o
);

  logic                  region_reg_s;
  logic [RAM_ADDR_W-1:0] offset_s;
  logic                  mapped_s;

  assign region_reg_s = cdc_a_i[REGION_BIT];
  assign offset_s     = cdc_a_i[RAM_ADDR_W-1:0];
  assign mapped_s     = reg_offset_mapped(offset_s);

  // Decode the region and offset into strobes. The address fields are
  // driven whatever the region. Only the strobes and err depend on it.
  always_comb begin
    dec_o          = CDC_DEC_RESET;
    dec_o.mux      = region_reg_s;
    dec_o.ram_addr = offset_s;
    dec_o.reg_idx  = cdc_a_i[REG_IDX_W-1:0];
    if (region_reg_s) begin
      // A write to an unmapped register produces no strobe. It only
      // raises err, and err is raised for reads as well.
      dec_o.wr_ram = 1'b0;
      dec_o.wr_rej = cdc_wr_i & mapped_s;
      dec_o.err    = ~mapped_s;
    end else begin
      dec_o.wr_ram = cdc_wr_i;
      dec_o.wr_rej = 1'b0;
      dec_o.err    = 1'b0;
    end
  end

endmodule

// File: rtl/cdc_addr_decoder.sv
// ---------------------------------------------------------------------------
// cdc_addr_decoder
// Purpose : Address decoder behind the CDC bus interface of the FIR block.
//           The decode is registered once in the core clock domain, giving a
//           latency of 1 cycle. The read-back multiplexer is combinational
//           from the registered select.
// Ports   : clk          in  1       core clock, rising edge
//           rst          in  1       asynchronous active-high reset
//           CDC_A        in  6       CDC address (bit 5 = region)
//           CDC_wr       in  1       write request, sampled every clk
//           RAM_rdata    in  DATA_W  read data from RAM
//           Rej_rdata    in  DATA_W  read data from the register bank
//           Dekoder_MUX  out 1       read-mux select (0 = RAM, 1 = registers)
//           address_RAM  out 5       RAM word address
//           wr_RAM       out 1       RAM write strobe
//           nr_Rejestru  out 3       register index
//           wr_Rej       out 1       register write strobe
//           addr_err     out 1       unmapped register access
//           CDC_rdata    out DATA_W  selected read data (0 on addr_err)
// ---------------------------------------------------------------------------
module cdc_addr_decoder
  import cdc_map_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CDC_ADDR_W-1:0] CDC_A,
  input  logic                  CDC_wr,
  input  logic [DATA_W-1:0]     RAM_rdata,
  input  logic [DATA_W-1:0]     Rej_rdata,
  output logic                  Dekoder_MUX,
  output logic [RAM_ADDR_W-1:0] address_RAM,
  output logic                  wr_RAM,
  output logic [REG_IDX_W-1:0]  nr_Rejestru,
  output logic                  wr_Rej,
  output logic                  addr_err,
  output logic [DATA_W-1:0]     CDC_rdata
);

  cdc_dec_t dec_d;
  cdc_dec_t dec_q;

  cdc_addr_decode_comb u_decode (
    .cdc_a_i  (CDC_A),
    .cdc_wr_i (CDC_wr),
    .dec_o    (dec_d)
  );

  // Output register stage. Reset clears it at once, so a write that is in
  // flight while rst is high never produces a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= CDC_DEC_RESET;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign Dekoder_MUX = dec_q.mux;
  assign address_RAM = dec_q.ram_addr;
  assign wr_RAM      = dec_q.wr_ram;
  assign nr_Rejestru = dec_q.reg_idx;
  assign wr_Rej      = dec_q.wr_rej;
  assign addr_err    = dec_q.err;

  // Read-back mux. It is driven from the registered select so that the
  // read data lines up with the registered address. Unmapped accesses
  // return zero.
  always_comb begin
    CDC_rdata = {DATA_W{1'b0}};
    if (dec_q.err) begin
      CDC_rdata = {DATA_W{1'b0}};
    end else if (dec_q.mux) begin
      CDC_rdata = Rej_rdata;
    end else begin
      CDC_rdata = RAM_rdata;
    end
  end

endmodule

// File: tb/tb_cdc_addr_decoder.sv
module tb_cdc_addr_decoder;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        CDC_A;
  logic              CDC_wr;
  logic [DATA_W-1:0] RAM_rdata;
  logic [DATA_W-1:0] Rej_rdata;
  logic              Dekoder_MUX;
  logic [4:0]        address_RAM;
  logic              wr_RAM;
  logic [2:0]        nr_Rejestru;
  logic              wr_Rej;
  logic              addr_err;
  logic [DATA_W-1:0] CDC_rdata;

  int checks = 0;
  int errors = 0;

  cdc_addr_decoder #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .CDC_A       (CDC_A),
    .CDC_wr      (CDC_wr),
    .RAM_rdata   (RAM_rdata),
    .Rej_rdata   (Rej_rdata),
    .Dekoder_MUX (Dekoder_MUX),
    .address_RAM (address_RAM),
    .wr_RAM      (wr_RAM),
    .nr_Rejestru (nr_Rejestru),
    .wr_Rej      (wr_Rej),
    .addr_err    (addr_err),
    .CDC_rdata   (CDC_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Check every output against explicit expected values.
  // rsel selects the expected read data: 0 = RAM, 1 = register bank, 2 = zero.
  task automatic chk_all(input string tag, input logic mux, input logic [4:0] addr,
                         input logic wram, input logic [2:0] idx, input logic wrej,
                         input logic err, input int rsel);
    logic [DATA_W-1:0] exp_rd;
    exp_rd = (rsel == 0) ? RAM_rdata : (rsel == 1) ? Rej_rdata : {DATA_W{1'b0}};
    chk({tag, ".mux"},   {31'd0, Dekoder_MUX}, {31'd0, mux});
    chk({tag, ".addr"},  {27'd0, address_RAM}, {27'd0, addr});
    chk({tag, ".wrram"}, {31'd0, wr_RAM},      {31'd0, wram});
    chk({tag, ".idx"},   {29'd0, nr_Rejestru}, {29'd0, idx});
    chk({tag, ".wrrej"}, {31'd0, wr_Rej},      {31'd0, wrej});
    chk({tag, ".err"},   {31'd0, addr_err},    {31'd0, err});
    chk({tag, ".rdata"}, {16'd0, CDC_rdata},   {16'd0, exp_rd});
  endtask

  // Reference model. It works from the address map with integer arithmetic:
  // addresses 0..31 are RAM, 32..39 are registers 0..7, and 40..63 are holes.
  task automatic chk_model(input string tag, input int a, input bit wr);
    bit is_reg;
    bit mapped;
    int off;
    is_reg = (a >= 32);
    off    = a % 32;
    mapped = !is_reg || (off < 8);
    chk_all(tag, is_reg, off[4:0], wr && !is_reg, a % 8,
            wr && is_reg && mapped, is_reg && !mapped,
            !mapped ? 2 : (is_reg ? 1 : 0));
  endtask

  // Drive inputs on the falling edge, let the rising edge sample them, then
  // change the read data to exercise the combinational read mux.
  task automatic apply(input logic [5:0] a, input logic wr);
    @(negedge clk);
    CDC_A     = a;
    CDC_wr    = wr;
    RAM_rdata = 16'($urandom);
    Rej_rdata = 16'($urandom);
    @(posedge clk);
    #1;
    RAM_rdata = 16'($urandom);
    Rej_rdata = 16'($urandom);
    #1;
  endtask

  typedef struct {
    logic [5:0] a;
    logic       wr;
    logic       e_mux;
    logic [4:0] e_addr;
    logic       e_wram;
    logic [2:0] e_idx;
    logic       e_wrej;
    logic       e_err;
    int         e_rsel;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{6'b000101, 1'b1, 1'b0, 5'd5,  1'b1, 3'd5, 1'b0, 1'b0, 0};
    vecs[1] = '{6'b000101, 1'b0, 1'b0, 5'd5,  1'b0, 3'd5, 1'b0, 1'b0, 0};
    vecs[2] = '{6'b000111, 1'b0, 1'b0, 5'd7,  1'b0, 3'd7, 1'b0, 1'b0, 0};
    vecs[3] = '{6'b100011, 1'b1, 1'b1, 5'd3,  1'b0, 3'd3, 1'b1, 1'b0, 1};
    vecs[4] = '{6'b100001, 1'b0, 1'b1, 5'd1,  1'b0, 3'd1, 1'b0, 1'b0, 1};
    vecs[5] = '{6'b011111, 1'b1, 1'b0, 5'd31, 1'b1, 3'd7, 1'b0, 1'b0, 0};
    vecs[6] = '{6'b101000, 1'b1, 1'b1, 5'd8,  1'b0, 3'd0, 1'b0, 1'b1, 2};
    vecs[7] = '{6'b111111, 1'b0, 1'b1, 5'd31, 1'b0, 3'd7, 1'b0, 1'b1, 2};

    // Reset: assert with a write pending. All outputs must be 0 at once.
    rst       = 1'b1;
    CDC_A     = 6'b000101;
    CDC_wr    = 1'b1;
    RAM_rdata = 16'hA5A5;
    Rej_rdata = 16'h5A5A;
    #1;
    chk_all("reset", 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_clk", 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    CDC_A  = 6'd0;
    CDC_wr = 1'b0;
    rst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("idle", 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].a, vecs[i].wr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_mux, vecs[i].e_addr, vecs[i].e_wram,
              vecs[i].e_idx, vecs[i].e_wrej, vecs[i].e_err, vecs[i].e_rsel);
    end

    // Outputs hold until the next edge even after the inputs change.
    apply(6'b100010, 1'b1);
    @(negedge clk);
    CDC_A  = 6'b000001;
    CDC_wr = 1'b0;
    #1;
    chk_all("hold", 1'b1, 5'd2, 1'b0, 3'd2, 1'b1, 1'b0, 1);

    // Back-to-back writes give back-to-back strobes.
    apply(6'b000011, 1'b1);
    chk_model("b2b0", 3, 1'b1);
    apply(6'b000100, 1'b1);
    chk_model("b2b1", 4, 1'b1);

    // Reset asserted mid-cycle with a register write pending: no strobe,
    // and the outputs clear asynchronously.
    apply(6'b100100, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_wr", 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst    = 1'b0;
    CDC_wr = 1'b0;
    CDC_A  = 6'b100100;
    @(posedge clk);
    #1;
    chk_model("post_rst", 36, 1'b0);

    // Randomized accesses checked against the model.
    for (int n = 0; n < 200; n++) begin
      int  a;
      bit  wr;
      a  = int'($urandom_range(0, 63));
      wr = 1'($urandom);
      apply(6'(a), wr);
      chk_model($sformatf("rnd%0d_a%0d_w%0d", n, a, wr), a, wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
